// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and master FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] ST_WR_RESP      = 3'd2;
  localparam logic [2:0] ST_RD_ADDR      = 3'd3;
  localparam logic [2:0] ST_RD_DATA      = 3'd4;
  localparam logic [2:0] ST_RESPOND      = 3'd5;

endpackage

// File: rtl/axi_lite_timeout.sv
// Per-transaction cycle counter with clear/enable; expired flags the cycle in which the count reaches LIMIT.
// Zero latency on expired; LIMIT = 0 disables it; count saturates at LIMIT and holds while disabled.
module axi_lite_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);
  localparam logic [CW-1:0] SAT  = CW'(LIMIT);

  logic [CW-1:0] count;

  // An enabled clear cycle counts as the first elapsed cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= enable ? CW'(1) : '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && enable && !clear && (count >= LAST);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: command/response stream in, AXI-Lite read/write out.
// Response no earlier than 3 cycles after the accept cycle; one command at a time, held off until the response is consumed.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_data,
  input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,
  output logic                    o_awvalid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  input  logic                    i_awready,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [1:0]              i_rresp,
  input  logic [DATA_WIDTH-1:0]   i_rdata
);

  import axi_lite_pkg::*;

  logic [2:0] state;
  logic       accept;
  logic       busy;
  logic       expired;
  logic       aw_done;
  logic       w_done;
  logic       phase_done;
  logic       abort;

  assign accept  = i_cmd_valid && o_cmd_ready;
  assign busy    = (state == ST_WR_ADDR_DATA) || (state == ST_WR_RESP) ||
                   (state == ST_RD_ADDR) || (state == ST_RD_DATA);
  assign aw_done = !o_awvalid || i_awready;
  assign w_done  = !o_wvalid || i_wready;

  // A handshake landing in the expiry cycle takes priority over the abort.
  assign phase_done = ((state == ST_WR_ADDR_DATA) && aw_done && w_done) ||
                      ((state == ST_WR_RESP) && i_bvalid) ||
                      ((state == ST_RD_ADDR) && i_arready) ||
                      ((state == ST_RD_DATA) && i_rvalid);
  assign abort = expired && !phase_done;

  axi_lite_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_axi_clk),
    .rst    (i_axi_rst),
    .clear  (accept),
    .enable (busy || accept),
    .expired(expired)
  );

  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      state         <= ST_IDLE;
      o_cmd_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_resp    <= RESP_OKAY;
      o_rsp_timeout <= 1'b0;
      o_awvalid     <= 1'b0;
      o_awaddr      <= '0;
      o_wvalid      <= 1'b0;
      o_wstrb       <= '0;
      o_wdata       <= '0;
      o_bready      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_araddr      <= '0;
      o_rready      <= 1'b0;
    end else if (abort) begin
      o_awvalid     <= 1'b0;
      o_wvalid      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_bready      <= 1'b0;
      o_rready      <= 1'b0;
      o_rsp_valid   <= 1'b1;
      o_rsp_data    <= '0;
      o_rsp_resp    <= RESP_SLVERR;
      o_rsp_timeout <= 1'b1;
      state         <= ST_RESPOND;
    end else begin
      case (state)
        ST_IDLE: begin
          o_cmd_ready <= !accept;
          if (accept) begin
            if (i_cmd_wr) begin
              o_awaddr  <= i_cmd_addr;
              o_wdata   <= i_cmd_data;
              o_wstrb   <= i_cmd_strb;
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
              state     <= ST_WR_ADDR_DATA;
            end else begin
              o_araddr  <= i_cmd_addr;
              o_arvalid <= 1'b1;
              state     <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_ADDR_DATA: begin
          if (i_awready) o_awvalid <= 1'b0;
          if (i_wready) o_wvalid <= 1'b0;
          if (aw_done && w_done) begin
            o_bready <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (i_bvalid) begin
            o_bready      <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_data    <= '0;
            o_rsp_resp    <= i_bresp;
            o_rsp_timeout <= 1'b0;
            state         <= ST_RESPOND;
          end
        end
        ST_RD_ADDR: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (i_rvalid) begin
            o_rready      <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_data    <= i_rdata;
            o_rsp_resp    <= i_rresp;
            o_rsp_timeout <= 1'b0;
            state         <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench: behavioural AXI-Lite slave with configurable stalls/responses, scoreboard-checked responses.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_wr = 1'b0;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_data = '0;
  logic [3:0]  i_cmd_strb = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] o_rsp_data;
  logic [1:0]  o_rsp_resp;
  logic        o_rsp_timeout;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [31:0] o_awaddr, o_wdata, o_araddr, i_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;

  always #5 clk = ~clk;

  axi_lite_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_axi_clk(clk), .i_axi_rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wstrb(o_wstrb), .o_wdata(o_wdata),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0, rise_cyc = 0, n_rsp = 0;
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, aw_stab_err = 0;
  logic arv_at_rise = 1'b0;

  int aw_delay = 0, w_delay = 0;
  bit ar_hang = 1'b0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] mem [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: inputs change only at negedge; a snapshot taken there is exactly what the next posedge sees.
  initial begin
    logic [31:0] w_addr, w_data, r_addr;
    logic [3:0]  w_strb;
    bit got_aw, got_w, got_ar, p_aw, p_w, p_b, p_ar, p_r;
    int aw_wait, w_wait;
    w_addr = '0; w_data = '0; r_addr = '0; w_strb = '0;
    got_aw = 0; got_w = 0; got_ar = 0; p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    aw_wait = 0; w_wait = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    i_arready = 0; i_rvalid = 0; i_rresp = 0; i_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        got_aw = 0; got_w = 0; got_ar = 0; p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
        aw_wait = 0; w_wait = 0;
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
        i_arready = 0; i_rvalid = 0; i_rresp = 0; i_rdata = 0;
      end else begin
        if (p_b) begin
          for (int b = 0; b < 4; b++)
            if (w_strb[b]) mem[w_addr[5:2]][8*b +: 8] = w_data[8*b +: 8];
          got_aw = 0; got_w = 0;
        end
        if (p_r) got_ar = 0;
        if (p_aw) got_aw = 1;
        if (p_w) got_w = 1;
        if (p_ar) got_ar = 1;
        if (o_awvalid) begin i_awready = (aw_wait >= aw_delay); aw_wait++; end
        else begin i_awready = 0; aw_wait = 0; end
        if (o_wvalid) begin i_wready = (w_wait >= w_delay); w_wait++; end
        else begin i_wready = 0; w_wait = 0; end
        i_bvalid  = got_aw && got_w;
        i_bresp   = i_bvalid ? bresp_cfg : 2'b00;
        i_arready = o_arvalid && !ar_hang;
        i_rvalid  = got_ar;
        i_rdata   = got_ar ? mem[r_addr[5:2]] : 32'h0;
        i_rresp   = got_ar ? rresp_cfg : 2'b00;
        p_aw = o_awvalid && i_awready;
        if (p_aw) w_addr = o_awaddr;
        p_w = o_wvalid && i_wready;
        if (p_w) begin w_data = o_wdata; w_strb = o_wstrb; end
        p_b  = i_bvalid && o_bready;
        p_ar = o_arvalid && i_arready;
        if (p_ar) r_addr = o_araddr;
        p_r  = i_rvalid && o_rready;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake, and tracks AXI valid activity.
  initial begin
    logic prev_rv, prev_awv, prev_awr;
    logic [31:0] prev_awaddr;
    rsp_t e;
    prev_rv = 0; prev_awv = 0; prev_awr = 0; prev_awaddr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (o_rsp_valid && !prev_rv) begin rise_cyc = cyc; arv_at_rise = o_arvalid || o_rready; end
        if (o_awvalid) aw_cyc++;
        if (o_wvalid) w_cyc++;
        if (o_arvalid) ar_cyc++;
        if (prev_awv && !prev_awr && (!o_awvalid || (o_awaddr != prev_awaddr))) aw_stab_err++;
        if (o_rsp_valid && i_rsp_ready) begin
          n_rsp++;
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'(o_rsp_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_data", 64'(o_rsp_data), 64'(e.data));
            chk("rsp_resp", 64'(o_rsp_resp), 64'(e.resp));
            chk("rsp_timeout", 64'(o_rsp_timeout), 64'(e.to));
          end
        end
      end
      prev_rv = o_rsp_valid; prev_awv = o_awvalid; prev_awr = i_awready; prev_awaddr = o_awaddr;
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input rsp_t exp);
    int n = 0;
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_data = data; i_cmd_strb = strb;
    while (!o_cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!o_cmd_ready) chk("cmd_accept", 64'(o_cmd_ready), 64'd1);
    else begin acc_cyc = cyc; sb.push_back(exp); end
    @(negedge clk);
    i_cmd_valid = 0; i_cmd_addr = '1; i_cmd_data = '1; i_cmd_strb = '1; i_cmd_wr = ~wr;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk({name, "_pending"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({o_cmd_ready, o_rsp_valid, o_rsp_resp, o_rsp_timeout, o_awvalid,
                             o_wvalid, o_bready, o_arvalid, o_rready}), 64'd0);
    chk({tag, "_rsp_data"}, 64'(o_rsp_data), 64'd0);
    chk({tag, "_awaddr"}, 64'(o_awaddr), 64'd0);
    chk({tag, "_wdata_wstrb"}, 64'({o_wstrb, o_wdata}), 64'd0);
    chk({tag, "_araddr"}, 64'(o_araddr), 64'd0);
  endtask

  initial begin
    int n, hold_err, rsp_before;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 0;

    // Zero-wait write then read-back
    aw_cyc = 0; w_cyc = 0;
    issue(1, 32'h04, 32'hA5A5_0001, 4'hF, '{data: 32'h0, resp: 2'b00, to: 1'b0});
    wait_done("wr_zero_wait");
    chk("wr_latency", 64'(rise_cyc - acc_cyc), 64'd3);
    chk("wr_aw_cycles", 64'(aw_cyc), 64'd1);
    chk("wr_w_cycles", 64'(w_cyc), 64'd1);
    issue(0, 32'h04, 32'h0, 4'h0, '{data: 32'hA5A5_0001, resp: 2'b00, to: 1'b0});
    wait_done("rd_zero_wait");
    chk("rd_latency", 64'(rise_cyc - acc_cyc), 64'd3);

    // AW stalled 5 cycles, W immediate; partial strobe
    aw_delay = 5; aw_cyc = 0; w_cyc = 0; aw_stab_err = 0; rsp_before = n_rsp;
    issue(1, 32'h08, 32'h1234_5678, 4'h3, '{data: 32'h0, resp: 2'b00, to: 1'b0});
    wait_done("wr_aw_stall");
    chk("aw_stall_latency", 64'(rise_cyc - acc_cyc), 64'd8);
    chk("aw_stall_aw_cycles", 64'(aw_cyc), 64'd6);
    chk("aw_stall_w_cycles", 64'(w_cyc), 64'd1);
    chk("aw_stall_stability", 64'(aw_stab_err), 64'd0);
    chk("aw_stall_rsp_count", 64'(n_rsp - rsp_before), 64'd1);
    aw_delay = 0;
    issue(0, 32'h08, 32'h0, 4'h0, '{data: 32'h0000_5678, resp: 2'b00, to: 1'b0});
    wait_done("rd_strobe");

    // Error responses pass through
    bresp_cfg = 2'b11;
    issue(1, 32'h0C, 32'hDEAD_BEEF, 4'hF, '{data: 32'h0, resp: 2'b11, to: 1'b0});
    wait_done("wr_decerr");
    bresp_cfg = 2'b00; rresp_cfg = 2'b10;
    issue(0, 32'h0C, 32'h0, 4'h0, '{data: 32'hDEAD_BEEF, resp: 2'b10, to: 1'b0});
    wait_done("rd_slverr");
    rresp_cfg = 2'b00;

    // Slave never accepts AR: timeout abort
    ar_hang = 1; ar_cyc = 0;
    issue(0, 32'h10, 32'h0, 4'h0, '{data: 32'h0, resp: 2'b10, to: 1'b1});
    wait_done("rd_timeout");
    chk("timeout_latency", 64'(rise_cyc - acc_cyc), 64'd16);
    chk("timeout_ar_cycles", 64'(ar_cyc), 64'd15);
    chk("timeout_axi_dropped", 64'(arv_at_rise), 64'd0);
    ar_hang = 0;

    // Slow consumer: response held 40 cycles, no timeout
    i_rsp_ready = 0;
    issue(0, 32'h04, 32'h0, 4'h0, '{data: 32'hA5A5_0001, resp: 2'b00, to: 1'b0});
    n = 0;
    while (!o_rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("hold_rsp_valid", 64'(o_rsp_valid), 64'd1);
    h_data = o_rsp_data; h_resp = o_rsp_resp; hold_err = 0;
    repeat (40) begin
      @(negedge clk);
      if (!o_rsp_valid || o_rsp_data != h_data || o_rsp_resp != h_resp ||
          o_rsp_timeout || o_cmd_ready) hold_err++;
    end
    chk("hold_stable", 64'(hold_err), 64'd0);
    chk("hold_latency", 64'(rise_cyc - acc_cyc), 64'd3);
    i_rsp_ready = 1;
    wait_done("hold_release");

    // Asynchronous reset while W is stalled
    w_delay = 20;
    issue(1, 32'h14, 32'h1111_2222, 4'hF, '{data: 32'h0, resp: 2'b00, to: 1'b0});
    n = 0;
    while (!o_wvalid && n < 20) begin @(negedge clk); n++; end
    chk("pre_reset_wvalid", 64'(o_wvalid), 64'd1);
    #2 rst = 1;
    #1 check_zero("async_reset");
    sb.delete();
    w_delay = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    issue(0, 32'h00, 32'h0, 4'h0, '{data: 32'h0, resp: 2'b00, to: 1'b0});
    wait_done("rd_after_reset");
    chk("rd_after_reset_latency", 64'(rise_cyc - acc_cyc), 64'd3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator.
- Converts a simple command/response stream into AXI-Lite read and write transactions.
- Drives the slave-side cores (lightshow and peers) from benches and from local sequencer logic, replacing hand-written AXI stimulus.
- Includes a per-transaction timeout so a hung slave cannot stall the issuer.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width (32 or 64).
- STROBE_WIDTH, DATA_WIDTH/8, write-strobe width.
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction before abort; 0 disables the timeout.

Ports:
- i_axi_clk  in  1  clock.
- i_axi_rst  in  1  asynchronous reset, active-high.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  master idle, accepts command.
- i_cmd_wr  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_WIDTH  target address.
- i_cmd_data  in  DATA_WIDTH  write data.
- i_cmd_strb  in  STROBE_WIDTH  write strobes.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumed.
- o_rsp_data  out  DATA_WIDTH  read data (0 for writes).
- o_rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- o_rsp_timeout  out  1  transaction aborted by timeout.
- o_awvalid  out  1, o_awaddr  out  ADDR_WIDTH, i_awready  in  1.
- o_wvalid  out  1, i_wready  in  1, o_wstrb  out  STROBE_WIDTH, o_wdata  out  DATA_WIDTH.
- i_bvalid  in  1, o_bready  out  1, i_bresp  in  2.
- o_arvalid  out  1, i_arready  in  1, o_araddr  out  ADDR_WIDTH.
- i_rvalid  in  1, o_rready  out  1, i_rresp  in  2, i_rdata  in  DATA_WIDTH.

Behaviour:
- Reset, applied asynchronously:
  - FSM to IDLE.
  - All valid, ready and response outputs 0.
  - Address, data and strobe outputs 0.
  - Timeout counter 0.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- Commands:
  - o_cmd_ready = 1 only in IDLE.
  - Command accepted on i_cmd_valid & o_cmd_ready.
  - Address, data and strobe are registered on acceptance; later command-input changes are ignored.
- Write:
  - On accept, o_awvalid and o_wvalid both assert on the next cycle (1-cycle latency).
  - Each valid deasserts independently the cycle after its own handshake (valid & ready). AW and W may complete in either order or the same cycle.
  - When both are done, go to WR_RESP with o_bready = 1.
  - On i_bvalid, capture i_bresp, set o_rsp_data = 0, go to RESPOND.
- Read:
  - On accept, o_arvalid asserts next cycle.
  - After the AR handshake, go to RD_DATA with o_rready = 1.
  - On i_rvalid, capture i_rdata and i_rresp, go to RESPOND.
- Valid stability: once asserted, AW/W/AR valids and their payloads hold until handshake. The only exception is the timeout abort.
- o_bready and o_rready are asserted only in WR_RESP and RD_DATA respectively, never earlier.
- RESPOND:
  - o_rsp_valid = 1; response fields are held stable until i_rsp_ready.
  - On the handshake, return to IDLE; the next command is accepted no earlier than the following cycle.
  - Minimum command-to-response latency is 3 cycles with a zero-wait slave.
- Timeout:
  - Counter clears on command accept and increments each cycle in the WR_* and RD_* states.
  - At count == TIMEOUT_CYCLES: drop all AXI valids and readies, set o_rsp_resp = 2'b10, o_rsp_timeout = 1, o_rsp_data = 0, go to RESPOND.
  - The abort deliberately breaks AXI valid stability. It exists for debug/bench use only.
  - The counter is held in RESPOND, so a slow consumer never triggers a timeout.
  - A handshake completing in the same cycle the count is reached wins; no timeout is flagged.
- Reset mid-transaction: all outputs drop immediately, and any in-flight AXI transaction is abandoned.
- Only one transaction is outstanding; no ID or ordering logic.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - FSM state encoding constants.
- One natural sub-module, axi_lite_timeout: counter with clear, enable and an expired flag, reusable by other masters.

Test Plan:
- Zero-wait slave (lightshow bench). Write addr 0x04, data 0xA5A5_0001, strb 0xF, then read 0x04 -> write rsp_resp 0, read rsp_data 0xA5A5_0001 with rsp_resp 0; AW and W each asserted exactly 1 cycle.
- Slave holds awready low 5 cycles, wready immediate -> W completes first; awvalid and awaddr are stable for all 5 cycles; one response only after the B handshake.
- Slave returns BRESP 2'b11 on write and RRESP 2'b10 on read -> o_rsp_resp passes each through; o_rsp_timeout = 0.
- TIMEOUT_CYCLES = 16, slave never asserts arready -> o_arvalid drops, o_rsp_valid rises 16 cycles after accept, resp 2'b10, timeout 1.
- i_rsp_ready held low 40 cycles with TIMEOUT_CYCLES = 16 -> response held stable, no timeout, o_cmd_ready stays 0 until the response handshake.
- Assert i_axi_rst while o_wvalid = 1 -> all outputs 0 in the same cycle (asynchronous); after release, a read to 0x00 completes normally.
